// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register for a multi-lane core: hold/bubble stall handling,
// flush, x0/collision write suppression, write-back forwarding and retire counter.
module mem_wb_multi #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned LANES      = 2,
   parameter int unsigned STALL_W    = 6,
   parameter int unsigned STAGE_IDX  = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [STALL_W-1:0]            stall,
   input  logic                          flush,
   input  logic [LANES*XLEN-1:0]         mem_rd_data,
   input  logic [LANES*REG_ADDR_W-1:0]   mem_rd_addr,
   input  logic [LANES-1:0]              mem_rd_enable,
   output logic [LANES*XLEN-1:0]         wb_rd_data,
   output logic [LANES*REG_ADDR_W-1:0]   wb_rd_addr,
   output logic [LANES-1:0]              wb_rd_enable,
   input  logic [REG_ADDR_W-1:0]         fwd_addr,
   output logic                          fwd_hit,
   output logic [XLEN-1:0]               fwd_data,
   output logic [CNT_W-1:0]              retire_cnt
);

   localparam int unsigned WB_IDX = STAGE_IDX + 1;

   logic             mem_stall_c;
   logic             wb_stall_c;
   logic [LANES-1:0] cap_en_c;
   logic [CNT_W-1:0] wb_pop_c;

   assign mem_stall_c = stall[STAGE_IDX];
   assign wb_stall_c  = stall[WB_IDX];

   // Capture enables: drop writes to x0 and any write shadowed by a younger lane.
   always_comb begin
      cap_en_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         cap_en_c[i] = mem_rd_enable[i] &&
                       (mem_rd_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0);
         for (int unsigned j = i + 1; j < LANES; j++) begin
            if (mem_rd_enable[j] &&
                (mem_rd_addr[j*REG_ADDR_W +: REG_ADDR_W] ==
                 mem_rd_addr[i*REG_ADDR_W +: REG_ADDR_W]))
               cap_en_c[i] = 1'b0;
         end
      end
   end

   // Number of writes currently retiring from the WB stage.
   always_comb begin
      wb_pop_c = '0;
      for (int unsigned i = 0; i < LANES; i++)
         wb_pop_c = wb_pop_c + CNT_W'(wb_rd_enable[i]);
   end

   // Forwarding lookup; later (younger) lanes override older matches.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (wb_rd_enable[i] && (fwd_addr != '0) &&
             (wb_rd_addr[i*REG_ADDR_W +: REG_ADDR_W] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_rd_data[i*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_rd_data   <= '0;
         wb_rd_addr   <= '0;
         wb_rd_enable <= '0;
         retire_cnt   <= '0;
      end else begin
         if (flush || (mem_stall_c && !wb_stall_c)) begin
            wb_rd_data   <= '0;
            wb_rd_addr   <= '0;
            wb_rd_enable <= '0;
         end else if (!mem_stall_c) begin
            wb_rd_data   <= mem_rd_data;
            wb_rd_addr   <= mem_rd_addr;
            wb_rd_enable <= cap_en_c;
         end
         // Held WB entries are counted once, on the edge they finally leave.
         if (!wb_stall_c)
            retire_cnt <= retire_cnt + wb_pop_c;
      end
   end

endmodule

// File: tb/tb_mem_wb_multi.sv
// Scoreboard bench for mem_wb_multi (LANES=2, CNT_W=4): directed cases then random traffic.
module tb_mem_wb_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [63:0] mem_rd_data;
   logic [9:0]  mem_rd_addr;
   logic [1:0]  mem_rd_enable;
   logic [63:0] wb_rd_data;
   logic [9:0]  wb_rd_addr;
   logic [1:0]  wb_rd_enable;
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [3:0]  retire_cnt;

   mem_wb_multi #(.XLEN(32), .REG_ADDR_W(5), .LANES(2), .STALL_W(6),
                  .STAGE_IDX(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr),
      .mem_rd_enable(mem_rd_enable), .wb_rd_data(wb_rd_data),
      .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .retire_cnt(retire_cnt));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  en;
      logic [9:0]  addr;
      logic [63:0] data;
      logic        hit;
      logic [31:0] fdata;
      logic [3:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference state: what the register file will see next, as plain arrays.
   bit          m_en[2];
   logic [4:0]  m_addr[2];
   logic [31:0] m_data[2];
   int          m_cnt;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: one registered result per clock, compared away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("wb_rd_enable", 64'(wb_rd_enable), 64'(e.en));
         check("wb_rd_addr",   64'(wb_rd_addr),   64'(e.addr));
         check("wb_rd_data",   wb_rd_data,        e.data);
         check("fwd_hit",      64'(fwd_hit),      64'(e.hit));
         check("fwd_data",     64'(fwd_data),     64'(e.fdata));
         check("retire_cnt",   64'(retire_cnt),   64'(e.cnt));
      end
   end

   // Drive one cycle of inputs and queue the state expected after the next edge.
   task automatic step(input logic r, input logic [5:0] s, input logic f,
                       input logic [1:0] e, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] fa);
      logic [4:0]  ain[2];
      logic [31:0] din[2];
      int          owner[int];
      exp_t        x;
      bit          found;
      @(negedge clk); #1;
      rst = r; stall = s; flush = f; mem_rd_enable = e;
      mem_rd_addr = {a1, a0}; mem_rd_data = {d1, d0}; fwd_addr = fa;
      ain[0] = a0; ain[1] = a1; din[0] = d0; din[1] = d1;

      if (r) begin
         m_cnt = 0;
         foreach (m_en[i]) begin m_en[i] = 0; m_addr[i] = '0; m_data[i] = '0; end
      end else begin
         if (!s[5]) m_cnt = (m_cnt + int'(m_en[0]) + int'(m_en[1])) % 16;
         if (f || (s[4] && !s[5])) begin
            foreach (m_en[i]) begin m_en[i] = 0; m_addr[i] = '0; m_data[i] = '0; end
         end else if (!s[4]) begin
            // The last lane in program order to name a register owns that write.
            owner.delete();
            for (int i = 0; i < 2; i++)
               if (e[i] && ain[i] != 0) owner[int'(ain[i])] = i;
            for (int i = 0; i < 2; i++) begin
               m_en[i]   = e[i] && ain[i] != 0 && owner[int'(ain[i])] == i;
               m_addr[i] = ain[i];
               m_data[i] = din[i];
            end
         end
      end

      x.en    = {m_en[1], m_en[0]};
      x.addr  = {m_addr[1], m_addr[0]};
      x.data  = {m_data[1], m_data[0]};
      x.cnt   = 4'(m_cnt);
      x.hit   = 1'b0;
      x.fdata = '0;
      found   = 0;
      for (int i = 1; i >= 0; i--)
         if (!found && fa != 0 && m_en[i] && m_addr[i] == fa) begin
            found = 1; x.hit = 1'b1; x.fdata = m_data[i];
         end
      exp_q.push_back(x);
   endtask

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0; mem_rd_enable = '0;
      mem_rd_addr = '0; mem_rd_data = '0; fwd_addr = '0;
      m_cnt = 0;
      foreach (m_en[i]) begin m_en[i] = 0; m_addr[i] = '0; m_data[i] = '0; end

      // Reset with live inputs
      step(1, 6'b000000, 0, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 5'd3);
      step(1, 6'b110000, 1, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 5'd4);
      // Advance and forward
      step(0, 6'b000000, 0, 2'b11, 5'd5, 5'd6, 32'h11, 32'h22, 5'd6);
      step(0, 6'b000000, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5);
      // Same-address collision: only the younger lane writes
      step(0, 6'b000000, 0, 2'b11, 5'd9, 5'd9, 32'hAA, 32'hBB, 5'd9);
      // Hold over three cycles with junk inputs
      step(0, 6'b110000, 0, 2'b11, 5'd1, 5'd2, 32'hDEAD, 32'hBEEF, 5'd9);
      step(0, 6'b110000, 0, 2'b01, 5'd7, 5'd8, 32'h1, 32'h2, 5'd9);
      step(0, 6'b110000, 0, 2'b10, 5'd7, 5'd8, 32'h1, 32'h2, 5'd9);
      // MEM stalled, WB free: bubble
      step(0, 6'b010000, 0, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 5'd1);
      // Advance with WB-only stall bit set, plus x0 suppression on lane 0
      step(0, 6'b100000, 0, 2'b11, 5'd0, 5'd12, 32'h77, 32'h88, 5'd0);
      step(0, 6'b000000, 0, 2'b11, 5'd13, 5'd14, 32'h99, 32'hAB, 5'd12);
      // Flush with valid inputs
      step(0, 6'b000000, 1, 2'b11, 5'd15, 5'd16, 32'hC0, 32'hC1, 5'd15);
      step(0, 6'b000000, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0);
      // Counter wrap: 7 dual writes reach 14, one more wraps to 0
      step(1, 6'b000000, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0);
      for (int k = 0; k < 9; k++)
         step(0, 6'b000000, 0, 2'b11, 5'(2*k+1), 5'(2*k+2), 32'(k), 32'(k+100), 5'(2*k+2));
      step(0, 6'b000000, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0);

      // Random traffic with a small address space to provoke collisions
      for (int k = 0; k < 400; k++) begin
         logic [5:0] s;
         s = 6'($urandom);
         s[4] = ($urandom_range(0, 3) == 0);
         s[5] = ($urandom_range(0, 3) == 0);
         step(($urandom_range(0, 49) == 0), s, ($urandom_range(0, 9) == 0),
              2'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              32'($urandom), 32'($urandom), 5'($urandom_range(0, 3)));
      end

      // Drain the scoreboard within a bounded number of cycles
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_wb_multi.md
Name: mem_wb_multi

Overview:
- Parametrised MEM/WB pipeline register for multi-lane (superscalar-ready) cores; sits between the memory-access stage and the register-file write port.
- Adds, relative to a single-lane latch:
  - LANES parallel write-back lanes.
  - Correct hold-versus-bubble stall semantics.
  - A flush input.
  - x0 and same-address write suppression.
  - A write-back forwarding lookup port.
  - A retired-write counter.

Parameters:
- XLEN, 32, register data width.
- REG_ADDR_W, 5, register address width.
- LANES, 2, number of write-back lanes (1..4); lane LANES-1 is youngest in program order.
- STALL_W, 6, width of the global stall vector.
- STAGE_IDX, 4, stall bit owned by the MEM stage; bit STAGE_IDX+1 is the WB stage. Requires STAGE_IDX+1 < STALL_W.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  global stall vector.
- flush  in  1  kill the in-flight MEM results (branch mispredict/exception).
- mem_rd_data  in  LANES*XLEN  lane i at bits [i*XLEN +: XLEN].
- mem_rd_addr  in  LANES*REG_ADDR_W  lane i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- mem_rd_enable  in  LANES  per-lane write enable.
- wb_rd_data  out  LANES*XLEN  registered.
- wb_rd_addr  out  LANES*REG_ADDR_W  registered.
- wb_rd_enable  out  LANES  registered.
- fwd_addr  in  REG_ADDR_W  forwarding query address.
- fwd_hit  out  1  combinational.
- fwd_data  out  XLEN  combinational.
- retire_cnt  out  CNT_W  registered count of write-back-stage writes.

Behaviour:
- Reset: all wb_* outputs 0; retire_cnt 0. Reset has top priority and applies mid-stall or mid-flush.
- Per-edge action, in priority order:
  1. rst → clear all outputs and the counter.
  2. flush → bubble.
  3. stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0 → bubble.
  4. stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=1 → hold; all wb_* outputs keep their value.
  5. Otherwise (stall[STAGE_IDX]=0) → advance; capture the mem_* inputs.
  - stall[STAGE_IDX]=0 with stall[STAGE_IDX+1]=1 is treated as advance.
- Bubble: wb_rd_enable, wb_rd_addr and wb_rd_data all 0.
- Latency: 1 cycle from mem_* to wb_*.
- Enable rules at capture:
  - x0 suppression: lane enable forced 0 when its addr==0. Data and addr are still captured.
  - Collision: if lanes i<j are both enabled with the same nonzero addr, lane i's enable is cleared. Only the youngest lane writes.
- Forwarding (combinational on registered state):
  - fwd_hit=1 iff some lane has wb_rd_enable=1 and wb_rd_addr==fwd_addr, with fwd_addr≠0.
  - fwd_data = data of the youngest matching lane.
  - No hit → fwd_data=0.
- retire_cnt:
  - On each posedge where rst=0 and stall[STAGE_IDX+1]=0, increments by the popcount of the current wb_rd_enable.
  - Wraps modulo 2^CNT_W.
  - Not cleared by flush.
  - Does not increment while the WB stage is stalled, so held entries are not double-counted.
- LANES=1 degenerates to a single-lane register with no collision logic.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero inputs → all wb_* = 0, retire_cnt=0, fwd_hit=0.
- Advance, LANES=2:
  - Inputs: lane0 (addr 5, data 0x11, en 1), lane1 (addr 6, data 0x22, en 1), stall=0.
  - Next cycle wb_* match the inputs.
  - fwd_addr=6 → hit, data 0x22.
  - Following cycle retire_cnt=2.
- Stall semantics:
  - stall=6'b010000 → bubble: wb_rd_enable=0.
  - stall=6'b110000 → previous wb_* held unchanged over 3 cycles; retire_cnt constant.
- Suppression:
  - lane0 (addr 0, en 1) → wb_rd_enable[0]=0.
  - Both lanes (addr 9, en 1), data 0xAA/0xBB → wb_rd_enable=2'b10; fwd_addr=9 gives 0xBB.
- Flush priority: flush=1 with stall=0 and valid inputs → bubble; retire_cnt unaffected on the flush edge except for writes already in WB.
- Wrap: CNT_W=4, preload via 7 cycles of 2 writes (count 14), then one more dual write → retire_cnt=0.
